// File: rtl/instr_encoder.sv
// RV64I field-to-word encoder with a 2-entry output FIFO and a sequential address tag.
// Optional immediate range checking is compiled in with INSTR_ENC_RANGE_CHK_EN.
module instr_encoder #(
    parameter logic [31:0] RESET_ADDR = 32'h0000_0000,
    parameter logic [31:0] ADDR_STEP  = 32'd4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [6:0]  in_opcode,
    input  logic [2:0]  in_funct3,
    input  logic [6:0]  in_funct7,
    input  logic [4:0]  in_rs1,
    input  logic [4:0]  in_rs2,
    input  logic [4:0]  in_rd,
    input  logic [31:0] in_imm,
    input  logic        pc_load,
    input  logic [31:0] pc_value,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_instr,
    output logic [31:0] out_addr,
    output logic        out_err,
    output logic [15:0] enc_count
);

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] addr;
        logic        err;
    } entry_t;

    entry_t      head;
    entry_t      tail;
    entry_t      new_entry;
    logic [1:0]  occ;
    logic [1:0]  occ_next;
    logic        ready_q;
    logic [31:0] pc;
    logic [31:0] pc_next;
    logic [31:0] tag_addr;
    logic [15:0] count;
    logic        accept;
    logic        xfer;
    logic [31:0] enc_instr;
    logic        op_err;
    logic        entry_err;
    logic        is_shift;

    assign accept   = in_valid && ready_q;
    assign xfer     = (occ != 2'd0) && out_ready;
    assign is_shift = (in_funct3 == 3'b001) || (in_funct3 == 3'b101);

    always_comb begin
        enc_instr = 32'h0000_0013;
        op_err    = 1'b0;
        case (in_opcode)
            7'b0110011: enc_instr = {in_funct7, in_rs2, in_rs1, in_funct3, in_rd, in_opcode};
            7'b0010011, 7'b0011011: begin
                if (is_shift)
                    enc_instr = {in_funct7, in_imm[4:0], in_rs1, in_funct3, in_rd, in_opcode};
                else
                    enc_instr = {in_imm[11:0], in_rs1, in_funct3, in_rd, in_opcode};
            end
            7'b0000011, 7'b1100111:
                enc_instr = {in_imm[11:0], in_rs1, in_funct3, in_rd, in_opcode};
            7'b0100011:
                enc_instr = {in_imm[11:5], in_rs2, in_rs1, in_funct3, in_imm[4:0], in_opcode};
            7'b1100011:
                enc_instr = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, in_funct3,
                             in_imm[4:1], in_imm[11], in_opcode};
            7'b0110111, 7'b0010111:
                enc_instr = {in_imm[31:12], in_rd, in_opcode};
            7'b1101111:
                enc_instr = {in_imm[20], in_imm[10:1], in_imm[11], in_imm[19:12], in_rd, in_opcode};
            default: op_err = 1'b1;
        endcase
    end

`ifdef INSTR_ENC_RANGE_CHK_EN
    logic signed [31:0] simm;
    logic               rng_err;
    logic               i_rng;

    assign simm  = $signed(in_imm);
    assign i_rng = (simm < -32'sd2048) || (simm > 32'sd2047);

    always_comb begin
        rng_err = 1'b0;
        case (in_opcode)
            7'b0010011, 7'b0011011:
                rng_err = is_shift ? ((simm < 32'sd0) || (simm > 32'sd31)) : i_rng;
            7'b0000011, 7'b1100111, 7'b0100011: rng_err = i_rng;
            7'b1100011:
                rng_err = (simm < -32'sd4096) || (simm > 32'sd4094) || in_imm[0];
            7'b1101111:
                rng_err = (simm < -32'sd1048576) || (simm > 32'sd1048574) || in_imm[0];
            7'b0110111, 7'b0010111: rng_err = (in_imm[11:0] != 12'd0);
            default: rng_err = 1'b0;
        endcase
    end

    assign entry_err = op_err | rng_err;
`else
    assign entry_err = op_err;
`endif

    // pc_load takes effect before tagging an entry accepted in the same cycle
    assign tag_addr  = pc_load ? pc_value : pc;
    assign pc_next   = accept ? (tag_addr + ADDR_STEP) : (pc_load ? pc_value : pc);
    assign new_entry = '{instr: enc_instr, addr: tag_addr, err: entry_err};

    always_comb begin
        case ({accept, xfer})
            2'b10:   occ_next = occ + 2'd1;
            2'b01:   occ_next = occ - 2'd1;
            default: occ_next = occ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            occ     <= 2'd0;
            ready_q <= 1'b1;
            pc      <= RESET_ADDR;
            count   <= 16'd0;
            head    <= '0;
            tail    <= '0;
        end else begin
            occ     <= occ_next;
            ready_q <= (occ_next < 2'd2);
            pc      <= pc_next;
            if (accept)
                count <= count + 16'd1;
            // head is the visible entry; tail only fills while head is occupied and staying
            if (xfer)
                head <= (accept && occ == 2'd1) ? new_entry : tail;
            else if (accept && occ == 2'd0)
                head <= new_entry;
            if (accept && occ == 2'd1 && !xfer)
                tail <= new_entry;
        end
    end

    assign in_ready  = ready_q;
    assign out_valid = (occ != 2'd0);
    assign out_instr = head.instr;
    assign out_addr  = head.addr;
    assign out_err   = head.err;
    assign enc_count = count;

endmodule

// File: tb/tb_instr_encoder.sv
// Directed and randomized bench for instr_encoder; a negedge monitor compares every
// cycle against a queue-based model built from the instruction-format tables.
module tb_instr_encoder;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [6:0]  in_opcode;
    logic [2:0]  in_funct3;
    logic [6:0]  in_funct7;
    logic [4:0]  in_rs1;
    logic [4:0]  in_rs2;
    logic [4:0]  in_rd;
    logic [31:0] in_imm;
    logic        pc_load;
    logic [31:0] pc_value;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [31:0] out_addr;
    logic        out_err;
    logic [15:0] enc_count;

    int n_checks = 0;
    int n_fail   = 0;

    logic [64:0] exp_q[$];
    logic [31:0] m_pc;
    logic [15:0] m_cnt;

    instr_encoder dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_opcode(in_opcode), .in_funct3(in_funct3), .in_funct7(in_funct7),
        .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rd(in_rd), .in_imm(in_imm),
        .pc_load(pc_load), .pc_value(pc_value),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_instr(out_instr), .out_addr(out_addr), .out_err(out_err),
        .enc_count(enc_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Place a field value at bit position lsb of the word.
    function automatic logic [31:0] put(input logic [31:0] v, input int lsb);
        return v << lsb;
    endfunction

    function automatic logic [31:0] bits(input logic [31:0] v, input int lo, input int n);
        return (v >> lo) & ((32'd1 << n) - 32'd1);
    endfunction

    // Reference encoding: {err, word}
    function automatic logic [32:0] model_enc(input logic [6:0] op, input logic [2:0] f3,
                                              input logic [6:0] f7, input logic [4:0] rs1,
                                              input logic [4:0] rs2, input logic [4:0] rd,
                                              input logic [31:0] imm);
        logic [31:0] w;
        logic        err;
        int          si;
        logic        shift;
        si    = $signed(imm);
        shift = (f3 == 3'd1 || f3 == 3'd5);
        err   = 1'b0;
        w     = put(op, 0) | put(rd, 7) | put(f3, 12) | put(rs1, 15);
        case (op)
            7'h33: w = w | put(rs2, 20) | put(f7, 25);
            7'h13, 7'h1B, 7'h03, 7'h67: begin
                if ((op == 7'h13 || op == 7'h1B) && shift) begin
                    w = w | put(bits(imm, 0, 5), 20) | put(f7, 25);
`ifdef INSTR_ENC_RANGE_CHK_EN
                    err = (si < 0 || si > 31);
`endif
                end else begin
                    w = w | put(bits(imm, 0, 12), 20);
`ifdef INSTR_ENC_RANGE_CHK_EN
                    err = (si < -2048 || si > 2047);
`endif
                end
            end
            7'h23: begin
                w = put(op, 0) | put(bits(imm, 0, 5), 7) | put(f3, 12) | put(rs1, 15)
                    | put(rs2, 20) | put(bits(imm, 5, 7), 25);
`ifdef INSTR_ENC_RANGE_CHK_EN
                err = (si < -2048 || si > 2047);
`endif
            end
            7'h63: begin
                w = put(op, 0) | put(bits(imm, 11, 1), 7) | put(bits(imm, 1, 4), 8)
                    | put(f3, 12) | put(rs1, 15) | put(rs2, 20)
                    | put(bits(imm, 5, 6), 25) | put(bits(imm, 12, 1), 31);
`ifdef INSTR_ENC_RANGE_CHK_EN
                err = (si < -4096 || si > 4094 || (si % 2) != 0);
`endif
            end
            7'h37, 7'h17: begin
                w = put(op, 0) | put(rd, 7) | (imm & 32'hFFFF_F000);
`ifdef INSTR_ENC_RANGE_CHK_EN
                err = (bits(imm, 0, 12) != 0);
`endif
            end
            7'h6F: begin
                w = put(op, 0) | put(rd, 7) | put(bits(imm, 12, 8), 12)
                    | put(bits(imm, 11, 1), 20) | put(bits(imm, 1, 10), 21)
                    | put(bits(imm, 20, 1), 31);
`ifdef INSTR_ENC_RANGE_CHK_EN
                err = (si < -1048576 || si > 1048574 || (si % 2) != 0);
`endif
            end
            default: begin
                w   = 32'h0000_0013;
                err = 1'b1;
            end
        endcase
        return {err, w};
    endfunction

    // Monitor: compare current DUT state with the model, then apply this cycle's handshakes.
    always @(negedge clk) begin
        logic [64:0] e;
        logic [32:0] enc;
        logic [31:0] a;
        if (reset) begin
            exp_q.delete();
            m_pc  = 32'h0;
            m_cnt = 16'd0;
        end else begin
            check("out_valid", {31'd0, out_valid}, {31'd0, exp_q.size() != 0});
            check("in_ready", {31'd0, in_ready}, {31'd0, exp_q.size() < 2});
            check("enc_count", {16'd0, enc_count}, {16'd0, m_cnt});
            if (exp_q.size() != 0) begin
                e = exp_q[0];
                check("out_instr", out_instr, e[31:0]);
                check("out_addr", out_addr, e[63:32]);
                check("out_err", {31'd0, out_err}, {31'd0, e[64]});
                if (out_ready) void'(exp_q.pop_front());
            end
            if (in_valid && in_ready) begin
                enc = model_enc(in_opcode, in_funct3, in_funct7, in_rs1, in_rs2, in_rd, in_imm);
                a   = pc_load ? pc_value : m_pc;
                m_pc = a + 32'd4;
                exp_q.push_back({enc[32], a, enc[31:0]});
                m_cnt++;
            end else if (pc_load) begin
                m_pc = pc_value;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        in_valid = 1'b0;
        pc_load = 1'b0;
        repeat (2) step();
        reset = 1'b0;
    endtask

    // Present fields and hold until accepted (bounded); in_valid stays high on return.
    task automatic send(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7,
                        input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                        input logic [31:0] imm);
        logic acc;
        int   n;
        in_opcode = op; in_funct3 = f3; in_funct7 = f7;
        in_rs1 = rs1; in_rs2 = rs2; in_rd = rd; in_imm = imm;
        in_valid = 1'b1;
        acc = 1'b0;
        n = 0;
        while (!acc && n < 50) begin
            @(negedge clk);
            acc = in_ready;
            step();
            n++;
        end
        check("send_accept", {31'd0, acc}, 32'd1);
    endtask

    task automatic idle();
        in_valid = 1'b0;
        pc_load  = 1'b0;
    endtask

    task automatic expect_head(input string tag, input logic [31:0] instr,
                               input logic [31:0] addr, input logic err);
        @(negedge clk);
        check({tag, "_valid"}, {31'd0, out_valid}, 32'd1);
        check({tag, "_instr"}, out_instr, instr);
        check({tag, "_addr"}, out_addr, addr);
        check({tag, "_err"}, {31'd0, out_err}, {31'd0, err});
        step();
    endtask

    task automatic rand_fields();
        logic [6:0] ops [11];
        int k;
        ops = '{7'h33, 7'h13, 7'h1B, 7'h03, 7'h67, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6F, 7'h13};
        k = $urandom_range(0, 11);
        in_opcode = (k == 11) ? 7'($urandom_range(0, 127)) : ops[k];
        in_funct3 = 3'($urandom_range(0, 7));
        in_funct7 = 7'($urandom_range(0, 127));
        in_rs1 = 5'($urandom_range(0, 31));
        in_rs2 = 5'($urandom_range(0, 31));
        in_rd  = 5'($urandom_range(0, 31));
        case (in_opcode)
            7'h13, 7'h1B:
                if (in_funct3 == 3'd1 || in_funct3 == 3'd5) in_imm = $urandom_range(0, 31);
                else in_imm = $urandom_range(0, 4095) - 32'd2048;
            7'h03, 7'h67, 7'h23: in_imm = $urandom_range(0, 4095) - 32'd2048;
            7'h63: in_imm = ($urandom_range(0, 4095) - 32'd2048) << 1;
            7'h6F: in_imm = ($urandom_range(0, 1048575) - 32'd524288) << 1;
            7'h37, 7'h17: in_imm = $urandom << 12;
            default: in_imm = $urandom;
        endcase
    endtask

    initial begin
        logic exp_b5_err;
        int   n;
        reset = 1'b1; in_valid = 1'b0; pc_load = 1'b0; pc_value = 32'h0; out_ready = 1'b0;
        in_opcode = 7'h0; in_funct3 = 3'h0; in_funct7 = 7'h0;
        in_rs1 = 5'h0; in_rs2 = 5'h0; in_rd = 5'h0; in_imm = 32'h0;
        repeat (3) step();
        reset = 1'b0;

        // reset state
        @(negedge clk);
        check("rst_valid", {31'd0, out_valid}, 32'd0);
        check("rst_instr", out_instr, 32'h0);
        check("rst_addr", out_addr, 32'h0);
        check("rst_err", {31'd0, out_err}, 32'd0);
        check("rst_ready", {31'd0, in_ready}, 32'd1);
        check("rst_count", {16'd0, enc_count}, 32'd0);
        step();

        // ADD x3,x1,x2
        out_ready = 1'b1;
        send(7'h33, 3'd0, 7'd0, 5'd1, 5'd2, 5'd3, 32'd0); idle();
        expect_head("add", 32'h002081B3, 32'h0, 1'b0);

        // ADDI x1,x0,-1 then SW x5,8(x2)
        do_reset();
        send(7'h13, 3'd0, 7'd0, 5'd0, 5'd0, 5'd1, 32'hFFFF_FFFF); idle();
        expect_head("addi", 32'hFFF00093, 32'h0, 1'b0);
        send(7'h23, 3'd2, 7'd0, 5'd2, 5'd5, 5'd0, 32'd8); idle();
        expect_head("sw", 32'h00512423, 32'h4, 1'b0);

        // BEQ x1,x2,+8 then JAL x1,+2048
        do_reset();
        send(7'h63, 3'd0, 7'd0, 5'd1, 5'd2, 5'd0, 32'd8); idle();
        expect_head("beq", 32'h00208463, 32'h0, 1'b0);
        send(7'h6F, 3'd0, 7'd0, 5'd0, 5'd0, 5'd1, 32'd2048); idle();
        expect_head("jal", 32'h001000EF, 32'h4, 1'b0);
        @(negedge clk);
        check("count2", {16'd0, enc_count}, 32'd2);
        step();

        // backpressure: two accepts fill the buffer, the third waits
        do_reset();
        out_ready = 1'b0;
        send(7'h33, 3'd0, 7'd0, 5'd1, 5'd2, 5'd3, 32'd0);
        send(7'h33, 3'd0, 7'd0, 5'd4, 5'd5, 5'd6, 32'd0);
        in_rs1 = 5'd7;
        @(negedge clk);
        check("full_ready", {31'd0, in_ready}, 32'd0);
        step();
        @(negedge clk);
        check("hold_addr", out_addr, 32'h0);
        check("hold_ready", {31'd0, in_ready}, 32'd0);
        step();
        out_ready = 1'b1;
        send(7'h33, 3'd0, 7'd0, 5'd7, 5'd8, 5'd9, 32'd0); idle();
        repeat (4) step();
        @(negedge clk);
        check("bp_drained", {31'd0, out_valid}, 32'd0);
        check("bp_count", {16'd0, enc_count}, 32'd3);
        step();

        // pc_load alongside an accept
        do_reset();
        pc_value = 32'h100; pc_load = 1'b1;
        send(7'h37, 3'd0, 7'd0, 5'd0, 5'd0, 5'd4, 32'h1234_5000); idle();
        expect_head("lui_pc", 32'h12345237, 32'h100, 1'b0);
        send(7'h33, 3'd0, 7'd0, 5'd1, 5'd2, 5'd3, 32'd0); idle();
        expect_head("pc_next", 32'h002081B3, 32'h104, 1'b0);

        // unknown opcode and odd branch offset
        send(7'h7F, 3'd0, 7'd0, 5'd1, 5'd2, 5'd3, 32'd0); idle();
        expect_head("bad_op", 32'h00000013, 32'h108, 1'b1);
`ifdef INSTR_ENC_RANGE_CHK_EN
        exp_b5_err = 1'b1;
`else
        exp_b5_err = 1'b0;
`endif
        send(7'h63, 3'd0, 7'd0, 5'd1, 5'd2, 5'd0, 32'd5); idle();
        expect_head("beq_odd", 32'h00208263, 32'h10C, exp_b5_err);

        // reset while entries are buffered
        out_ready = 1'b0;
        send(7'h33, 3'd0, 7'd0, 5'd1, 5'd2, 5'd3, 32'd0);
        send(7'h33, 3'd0, 7'd0, 5'd1, 5'd2, 5'd3, 32'd0); idle();
        reset = 1'b1;
        step();
        reset = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        check("rst_mid_valid", {31'd0, out_valid}, 32'd0);
        check("rst_mid_count", {16'd0, enc_count}, 32'd0);
        step();

        // randomized traffic
        for (int i = 0; i < 600; i++) begin
            out_ready = ($urandom_range(0, 3) != 0);
            in_valid  = ($urandom_range(0, 2) != 0);
            pc_load   = ($urandom_range(0, 15) == 0);
            pc_value  = $urandom & 32'hFFFF_FFFC;
            rand_fields();
            step();
        end
        idle();
        out_ready = 1'b1;
        n = 0;
        while (exp_q.size() != 0 && n < 20) begin
            step();
            n++;
        end
        @(negedge clk);
        check("final_drain", {31'd0, out_valid}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
